branch_fetch_unit: RTL
======================

BRANCH_FETCH_UNIT -- requirements
Module: branch_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: fetch address loaded by reset.
REQ-002 Parameter BTB_IDX_W, default 5: BTB index width (32 entries); must match predictor address width.
REQ-003 Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 Stall  input  1  hazard unit holds fetch PC.
REQ-006 PredTaken  input  1  predictor's taken output for PredictAddr (combinational, same cycle).
REQ-007 Branch_EX  input  1  branch resolving in EX this cycle.
REQ-008 Outcome  input  1  resolved direction, 1 = taken.
REQ-009 PCPlus4_EX  input  32  PC+4 of the resolving branch.
REQ-010 Target_EX  input  32  computed branch target of the resolving branch.
REQ-011 PredTaken_EX  input  1  prediction made for that branch, carried down the pipeline.
REQ-012 PC  output  32  current fetch address.
REQ-013 PCPlus4_IF  output  32  PC+4, to IF/ID register.
REQ-014 PredictAddr  output  BTB_IDX_W  PCPlus4_IF[BTB_IDX_W+1:2], to predictor.
REQ-015 PredTaken_IF  output  1  redirect taken at fetch, to IF/ID register.
REQ-016 Flush  output  1  mispredict; squash IF/ID and ID/EX.
REQ-017 MispredictCount  output  16  saturating mispredict counter.

Function
REQ-018 BTB: 2^BTB_IDX_W entries of {valid, tag = PCPlus4[31:BTB_IDX_W+2], target[31:0]}, indexed by PC+4[BTB_IDX_W+1:2].
REQ-019 Hit = entry at PredictAddr valid and tag equal; PredTaken_IF = PredTaken AND Hit, combinational.
REQ-020 Mispredict = Branch_EX AND (Outcome != PredTaken_EX); Flush = Mispredict, combinational, same cycle.
REQ-021 Next-PC priority: Mispredict -> (Outcome ? Target_EX : PCPlus4_EX); else Stall -> hold PC; else PredTaken_IF -> BTB target; else PCPlus4_IF.
REQ-022 Mispredict overrides Stall; redirect lands on next rising edge (1-cycle latency).
REQ-023 BTB write on Branch_EX AND Outcome: set valid, tag and target from PCPlus4_EX/Target_EX; write ignores Stall.
REQ-024 Branch_EX AND NOT Outcome leaves BTB unchanged (direction owned by predictor).
REQ-025 Same-cycle read/write same index: lookup sees old contents; new contents visible next cycle.
REQ-026 PCPlus4_IF = PC + 32'd4, wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
REQ-027 MispredictCount increments by 1 per cycle with Mispredict; holds at 16'hFFFF.

Reset
REQ-028 Reset asserted: PC = RESET_PC, all BTB valid = 0, MispredictCount = 0, immediately (asynchronous).
REQ-029 During reset, Flush = 0 and PredTaken_IF = 0 regardless of inputs; tag/target contents need no reset.
REQ-030 Reset mid-redirect discards the pending redirect; first post-reset fetch is RESET_PC.

Structure
REQ-031 Shared package (include file) holds BTB_IDX_W, derived tag width, RESET_PC default, 32-bit word-size constants.
REQ-032 One sub-module, branch_target_buffer: storage, valid bits, tag compare, one read and one write port.
REQ-033 PC register, next-PC mux, mispredict logic and counter reside in branch_fetch_unit.

Verification
REQ-034 Reset, no branches, Stall=0 -> PC 0,4,8,...; Flush=0, PredTaken_IF=0.
REQ-035 Branch_EX=1, Outcome=1, PredTaken_EX=0, PCPlus4_EX=32'h14, Target_EX=32'h40 -> Flush=1 that cycle; next PC=32'h40; BTB[5] valid, target 32'h40; count=1.
REQ-036 Then refetch PC=32'h10 with PredTaken=1 -> PredTaken_IF=1; next PC=32'h40.
REQ-037 Stall=1 with mispredict (Outcome=0, PredTaken_EX=1, PCPlus4_EX=32'h24) -> next PC=32'h24 despite Stall.
REQ-038 Aliasing: BTB holds PC+4=32'h14; fetch PC=32'h90 (same index, different tag), PredTaken=1 -> PredTaken_IF=0, next PC=32'h94.
REQ-039 Force count 16'hFFFF, mispredict -> stays 16'hFFFF; assert Reset mid-cycle -> PC=RESET_PC and count=0 without a clock edge.

Source files
------------

// File: rtl/branch_fetch_unit_pkg.sv
// Shared constants for the fetch stage: word geometry, BTB sizing, reset PC.
// No logic, so no latency.
// No flow control.
package branch_fetch_unit_pkg;

  localparam int          WORD_W          = 32;
  localparam int          WORD_BYTES      = 4;
  localparam int          BYTE_OFS_W      = 2;
  localparam int          BTB_IDX_W_DFLT  = 5;
  localparam int          BTB_TAG_W_DFLT  = WORD_W - BTB_IDX_W_DFLT - BYTE_OFS_W;
  localparam logic [31:0] RESET_PC_DFLT   = 32'h0000_0000;
  localparam logic [15:0] MISPRED_CNT_MAX = 16'hFFFF;

  // Sequential fetch address; wraps naturally at 2^32.
  function automatic logic [31:0] next_word(input logic [31:0] addr);
    return addr + 32'(WORD_BYTES);
  endfunction

endpackage

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with one lookup and one update port.
// Lookup is combinational; an update becomes visible on the following cycle.
// Never stalls; the update port accepts a write every cycle.
module branch_target_buffer
  import branch_fetch_unit_pkg::*;
#(
  parameter int IDX_W = BTB_IDX_W_DFLT,
  parameter int TAG_W = WORD_W - IDX_W - BYTE_OFS_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [TAG_W-1:0]  rd_tag,
  output logic              rd_hit,
  output logic [31:0]       rd_target,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [31:0]       wr_target
);

  localparam int ENTRIES = 2 ** IDX_W;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_mem    [ENTRIES];
  logic [31:0]        target_mem [ENTRIES];

  // Valid bits are the only state that must be cleared; stale tags are harmless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag and target payload, written alongside the valid bit.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]    <= wr_tag;
      target_mem[wr_idx] <= wr_target;
    end
  end

  // Read sees pre-write contents when indices collide in the same cycle.
  assign rd_hit    = valid_q[rd_idx] && (tag_mem[rd_idx] == rd_tag);
  assign rd_target = target_mem[rd_idx];

endmodule

// File: rtl/branch_fetch_unit.sv
// Fetch PC generation with BTB redirect, mispredict recovery and mispredict counter.
// Next PC lands one cycle later; Flush and PredTaken_IF are combinational.
// Stall holds the PC, but a mispredict redirect overrides it.
module branch_fetch_unit
  import branch_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DFLT,
  parameter int          BTB_IDX_W = BTB_IDX_W_DFLT
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Stall,
  input  logic                 PredTaken,
  input  logic                 Branch_EX,
  input  logic                 Outcome,
  input  logic [31:0]          PCPlus4_EX,
  input  logic [31:0]          Target_EX,
  input  logic                 PredTaken_EX,
  output logic [31:0]          PC,
  output logic [31:0]          PCPlus4_IF,
  output logic [BTB_IDX_W-1:0] PredictAddr,
  output logic                 PredTaken_IF,
  output logic                 Flush,
  output logic [15:0]          MispredictCount
);

  localparam int TAG_W = WORD_W - BTB_IDX_W - BYTE_OFS_W;

  logic [31:0] pc_q;
  logic [31:0] next_pc;
  logic [15:0] mispred_cnt_q;
  logic        mispredict;
  logic        btb_hit;
  logic [31:0] btb_target;
  logic        btb_wr_en;

  assign PC              = pc_q;
  assign PCPlus4_IF      = next_word(pc_q);
  assign PredictAddr     = PCPlus4_IF[BTB_IDX_W+1:2];
  assign MispredictCount = mispred_cnt_q;

  // Reset gating keeps both control outputs quiet while Reset is held.
  assign mispredict   = !Reset && Branch_EX && (Outcome != PredTaken_EX);
  assign Flush        = mispredict;
  assign PredTaken_IF = !Reset && PredTaken && btb_hit;

  // Only taken branches allocate; not-taken direction lives in the predictor.
  assign btb_wr_en = Branch_EX && Outcome;

  branch_target_buffer #(
    .IDX_W (BTB_IDX_W),
    .TAG_W (TAG_W)
  ) u_btb (
    .clk       (Clk),
    .rst       (Reset),
    .rd_idx    (PredictAddr),
    .rd_tag    (PCPlus4_IF[31:BTB_IDX_W+2]),
    .rd_hit    (btb_hit),
    .rd_target (btb_target),
    .wr_en     (btb_wr_en),
    .wr_idx    (PCPlus4_EX[BTB_IDX_W+1:2]),
    .wr_tag    (PCPlus4_EX[31:BTB_IDX_W+2]),
    .wr_target (Target_EX)
  );

  // Next-PC priority: recovery, then stall, then predicted redirect, then sequential.
  always_comb begin
    next_pc = PCPlus4_IF;
    if (mispredict) begin
      next_pc = Outcome ? Target_EX : PCPlus4_EX;
    end else if (Stall) begin
      next_pc = pc_q;
    end else if (PredTaken_IF) begin
      next_pc = btb_target;
    end
  end

  // Fetch PC register; reset drops any redirect still in flight.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= next_pc;
    end
  end

  // Saturating count of recovery events.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      mispred_cnt_q <= 16'h0000;
    end else if (mispredict && (mispred_cnt_q != MISPRED_CNT_MAX)) begin
      mispred_cnt_q <= mispred_cnt_q + 16'd1;
    end
  end

endmodule
